// File: rtl/irq_pkg.sv
// Shared definitions for the peripheral-side interrupt request controller:
// handshake state encoding and the supported source-count ceiling.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int MAX_SRC = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder: bit 0 has the highest
// priority; valid is low when no request bit is set.
module irq_prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scanning downwards lets the lowest set index overwrite the others.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_request_ctrl.sv
// Collects rising-edge events into a pending register and runs the single-line
// IRQ / acknowledge / end-of-interrupt handshake towards the core.
module irq_request_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] event_in,
  input  logic             en_we,
  input  logic [N_SRC-1:0] en_wdata,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  active_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] enable,
  output logic             busy
);

  irq_state_e       state, state_nxt;
  logic [N_SRC-1:0] event_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] pend_clr;
  logic             cand_valid;
  logic [ID_W-1:0]  cand_id;
  logic             irq_nxt;
  logic [ID_W-1:0]  id_nxt;

  assign rise = event_in & ~event_q;
  assign cand = pending & enable;

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (cand),
    .valid (cand_valid),
    .idx   (cand_id)
  );

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    id_nxt    = active_id;
    pend_clr  = '0;
    case (state)
      IDLE: begin
        if (cand_valid) begin
          state_nxt = REQ;
          irq_nxt   = 1'b1;
          id_nxt    = cand_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt = SERVICE;
          irq_nxt   = 1'b0;
          pend_clr  = N_SRC'(1) << active_id;
        end
      end
      SERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      irq       <= 1'b0;
      active_id <= '0;
      busy      <= 1'b0;
      event_q   <= '0;
      pending   <= '0;
      enable    <= '0;
    end else begin
      state     <= state_nxt;
      irq       <= irq_nxt;
      active_id <= id_nxt;
      busy      <= (state_nxt != IDLE);
      event_q   <= event_in;
      // A rise on the acknowledged source at the same edge re-arms it.
      pending   <= (pending & ~pend_clr) | rise;
      if (en_we) enable <= en_wdata;
    end
  end

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed self-checking bench for irq_request_ctrl with hand-computed
// expectations for the request/acknowledge/end-of-interrupt sequences.
module tb_irq_request_ctrl;

  logic       clock;
  logic       reset_n;
  logic [3:0] event_in;
  logic       en_we;
  logic [3:0] en_wdata;
  logic       irq_ack;
  logic       eoi;
  logic       irq;
  logic [1:0] active_id;
  logic [3:0] pending;
  logic [3:0] enable;
  logic       busy;

  int n_checks = 0;
  int n_passed = 0;

  irq_request_ctrl #(.N_SRC(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .event_in  (event_in),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .irq       (irq),
    .active_id (active_id),
    .pending   (pending),
    .enable    (enable),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_en(input logic [3:0] mask);
    en_we = 1'b1; en_wdata = mask; step(); en_we = 1'b0;
  endtask

  task automatic pulse_event(input logic [3:0] bits);
    event_in = bits; step(); event_in = 4'b0000;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; event_in = '0; en_we = 1'b0; en_wdata = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    step(2);
    check("rst_irq",     irq,       0);
    check("rst_pending", pending,   0);
    check("rst_enable",  enable,    0);
    check("rst_busy",    busy,      0);
    check("rst_id",      active_id, 0);
    @(negedge clock); reset_n = 1'b1;
    step();

    // 1: single source, basic handshake, stray ack in IDLE ignored
    write_en(4'b1111);
    check("t1_enable", enable, 4'hf);
    pulse_ack();
    check("t1_stray_ack_busy", busy, 0);
    pulse_event(4'b0100);
    check("t1_pending", pending, 4'b0100);
    check("t1_irq_lat1", irq, 0);
    step();
    check("t1_irq", irq, 1);
    check("t1_id", active_id, 2);
    check("t1_busy", busy, 1);
    pulse_eoi();
    check("t1_eoi_in_req_irq", irq, 1);
    step();
    pulse_ack();
    check("t1_ack_irq", irq, 0);
    check("t1_ack_pending", pending, 0);
    check("t1_ack_busy", busy, 1);
    step();
    pulse_eoi();
    check("t1_eoi_busy", busy, 0);
    check("t1_eoi_irq", irq, 0);
    step();
    check("t1_idle_irq", irq, 0);

    // 2: simultaneous events, lower index first
    pulse_event(4'b1010);
    check("t2_pending", pending, 4'b1010);
    step();
    check("t2_id1", active_id, 1);
    check("t2_irq1", irq, 1);
    pulse_ack();
    check("t2_pend_after_ack", pending, 4'b1000);
    pulse_eoi();
    check("t2_irq_low_after_eoi", irq, 0);
    check("t2_busy_after_eoi", busy, 0);
    step();
    check("t2_irq3", irq, 1);
    check("t2_id3", active_id, 3);
    check("t2_pend3", pending, 4'b1000);
    pulse_ack();
    pulse_eoi();
    check("t2_pend_done", pending, 0);

    // 3: masked pending, released by enable write
    write_en(4'b0000);
    pulse_event(4'b0001);
    check("t3_pending", pending, 4'b0001);
    step(3);
    check("t3_masked_irq", irq, 0);
    write_en(4'b0001);
    check("t3_irq_edge1", irq, 0);
    step();
    check("t3_irq_edge2", irq, 1);
    check("t3_id", active_id, 0);
    pulse_ack();
    pulse_eoi();

    // 4: no retarget in REQ; ack+eoi same cycle keeps SERVICE
    write_en(4'b1111);
    pulse_event(4'b0100);
    step();
    check("t4_id2", active_id, 2);
    pulse_event(4'b0001);
    check("t4_id_frozen", active_id, 2);
    check("t4_pending", pending, 4'b0101);
    check("t4_irq_held", irq, 1);
    irq_ack = 1'b1; eoi = 1'b1; step(); irq_ack = 1'b0; eoi = 1'b0;
    check("t4_ackeoi_irq", irq, 0);
    check("t4_ackeoi_busy", busy, 1);
    check("t4_ackeoi_pend", pending, 4'b0001);
    step(2);
    check("t4_still_service", busy, 1);
    check("t4_still_no_irq", irq, 0);
    pulse_eoi();
    check("t4_eoi_busy", busy, 0);
    step();
    check("t4_next_irq", irq, 1);
    check("t4_next_id", active_id, 0);
    pulse_ack();
    pulse_eoi();

    // 5: rise on active source coincides with ack -> set wins
    pulse_event(4'b0100);
    step();
    check("t5_id2", active_id, 2);
    event_in = 4'b0100; irq_ack = 1'b1; step(); event_in = '0; irq_ack = 1'b0;
    check("t5_irq_low", irq, 0);
    check("t5_pend_kept", pending, 4'b0100);
    pulse_eoi();
    step();
    check("t5_rereq_irq", irq, 1);
    check("t5_rereq_id", active_id, 2);
    pulse_ack();
    pulse_eoi();

    // 6: asynchronous reset mid-SERVICE
    pulse_event(4'b0110);
    step();
    check("t6_id1", active_id, 1);
    pulse_ack();
    pulse_event(4'b0010);
    check("t6_pending", pending, 4'b0110);
    check("t6_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_pending", pending, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_enable", enable, 0);
    check("t6_async_id", active_id, 0);
    check("t6_async_irq", irq, 0);
    @(negedge clock); reset_n = 1'b1;
    step(3);
    check("t6_post_irq", irq, 0);
    check("t6_post_pending", pending, 0);

    // Event held high through reset release counts as a rise
    reset_n = 1'b0; event_in = 4'b0001;
    step();
    @(negedge clock); reset_n = 1'b1;
    step();
    check("held_rise_pending", pending, 4'b0001);
    check("held_rise_irq_masked", irq, 0);
    event_in = '0;
    step();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_request_ctrl.md
# irq_request_ctrl

Peripheral-side interrupt request controller: collects rising-edge events from up to N_SRC peripherals, holds them as pending, and drives the single level IRQ line into the processor's interrupt unit. The controller completes the IRQ/acknowledge/return handshake from the requester end:
- the processor's branch-to-ISR pulse is the acknowledge;
- the ISR signals end-of-interrupt before the next request is raised.

It sits between the I/O peripherals and the core's IRQ input.

## Interface
- N_SRC, 4, number of event sources (2..16)
- ID_W, $clog2(N_SRC), width of source index
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- event_in  in  N_SRC  per-source event level, synchronous to clock; a 0→1 transition is one event
- en_we  in  1  write strobe for enable register
- en_wdata  in  N_SRC  new enable mask (1 = source may request)
- irq_ack  in  1  one-cycle pulse from core when it branches to ISR
- eoi  in  1  one-cycle end-of-interrupt pulse from ISR
- irq  out  1  registered interrupt request to core
- active_id  out  ID_W  index of source being requested/serviced
- pending  out  N_SRC  pending register
- enable  out  N_SRC  enable register
- busy  out  1  high in REQ or SERVICE

## Operation
- Edge detect: event_q holds the previous event_in. rise = event_in & ~event_q.
- pending[i] is set at any edge where rise[i]=1, regardless of enable or state.
- Enable: en_we loads enable ← en_wdata. Masked pending bits are kept but never selected.
- Selection: cand = pending & enable. The lowest index set in cand wins; index 0 has the highest priority.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if cand≠0 → REQ. At that edge: irq←1, active_id←winner. active_id is frozen until the next IDLE→REQ transition.
  - REQ: on irq_ack=1 → SERVICE. At that edge: irq←0, pending[active_id]←0. A later enable change or a higher-priority arrival does not withdraw or retarget the request.
  - SERVICE: on eoi=1 → IDLE.
- Stray pulses: irq_ack is ignored outside REQ. eoi is ignored outside SERVICE. irq_ack and eoi in the same cycle in REQ: ack taken, eoi dropped.
- Same-edge set/clear of pending[active_id] (rise and ack at the same edge): set wins, so the bit stays 1.
- A new event on active_id during SERVICE re-sets its pending bit; it is re-requested after eoi.
- Reset (any time, including mid-handshake): state=IDLE, irq=0, active_id=0, pending=0, enable=0, event_q=0, busy=0.
- Because event_q resets to 0, an event_in held high through reset release counts as a rise on the first edge.

## Timing
- event_in rises before edge k → pending set at edge k → irq=1 after edge k+1, provided the source is enabled and the FSM is IDLE. Latency is 2 edges.
- irq_ack sampled at edge a → irq=0 and pending bit cleared after edge a.
- eoi at edge e → IDLE after e. If cand≠0, irq is reasserted after edge e+1.
- Minimum irq low time between two requests is 2 cycles. This guarantees the core's registered IRQ sample sees a deassertion.
- irq, active_id and busy are direct register outputs; there is no combinational path from inputs to outputs.

## Structure
- Shared package irq_pkg:
  - state enum: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2
  - MAX_SRC=16
- Sub-module irq_prio_enc: purely combinational lowest-index-first priority encoder, N_SRC→{valid, ID_W index}.
- Top level holds event_q, pending, enable and the FSM.

## Test plan
1. Reset, then en_wdata=4'b1111. Pulse event_in[2] at edge 5 → pending=4'b0100 after edge 5, irq=1 and active_id=2 after edge 6. irq_ack at edge 9 → irq=0, pending=0. eoi at edge 11 → busy=0.
2. event_in[3] and event_in[1] rise together → active_id=1. After ack/eoi → irq reasserts with active_id=3, pending=4'b1000 before its ack.
3. enable=4'b0000, event_in[0] rises → pending=4'b0001, irq stays 0. Write enable=4'b0001 → irq=1 two edges later.
4. In REQ with active_id=2, event_in[0] rises → active_id stays 2, pending=4'b0101. irq_ack+eoi same cycle → state SERVICE. A separate eoi later → next request targets id 0.
5. event_in[2] rises at the same edge as irq_ack for active_id=2 → pending[2] stays 1. Source 2 is requested again after eoi.
6. Assert reset_n=0 while in SERVICE with pending=4'b0110 → all outputs 0 immediately (asynchronous). After release with event_in=0, irq stays 0.
